// File: rtl/add_sub_mp.sv
// add_sub_mp: multi-word add/subtract unit. Operands stream in one WIDTH-bit
// word per accepted beat, least-significant word first. The carry is chained
// between words, and the sign, zero and overflow flags are produced on the
// last word of each operation.
module add_sub_mp #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub_sel,
  input  logic             sop,
  input  logic             eop,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             flags_valid,
  output logic             sign_reg,
  output logic             z_reg,
  output logic             ovf_reg
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [WIDTH-1:0]  r_s;
  logic                     r_cout, r_out_valid, r_carry, r_sub_lat, r_zacc;
  logic                     r_sign, r_z, r_ovf, r_fvalid;

  logic                     w_accept, w_first, w_sub_op, w_cin, w_cout;
  logic                     w_zacc, w_ovf_s, w_ovf, w_sign;
  logic signed [WIDTH-1:0]  w_bx, w_res;
  logic        [WIDTH:0]    w_sum;

  // Two's-complement overflow: both addends share a sign that the result lacks.
  function automatic logic sat_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // The unit stalls only while a result is held and not taken, or while in reset.
  assign in_ready = rst_n & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // A word opens a new operation if it is flagged sop, or if it arrives while
  // no operation is open.
  assign w_first  = sop | (r_state == IDLE);
  assign w_sub_op = w_first ? sub_sel : r_sub_lat;
  assign w_cin    = w_first ? sub_sel : r_carry;
  assign w_bx     = w_sub_op ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
  assign w_res    = w_sum[WIDTH-1:0];
  assign w_cout   = w_sum[WIDTH];
  assign w_zacc   = (w_first | r_zacc) & (w_res == '0);
  assign w_ovf_s  = sat_ovf(a, w_bx, w_res);
  assign w_ovf    = (SIGNED != 0) ? w_ovf_s : (w_cout ^ w_sub_op);
  assign w_sign   = (SIGNED != 0) ? (w_res[WIDTH-1] ^ w_ovf_s)
                                  : (w_sub_op ? ~w_cout : w_cout);

  // Next state: an accepted eop closes the operation; any other accepted word
  // leaves one open.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = eop ? IDLE : BUSY;
    end
  end

  // Operation state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Carry chain, latched operation type and zero accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry   <= 1'b0;
      r_sub_lat <= 1'b0;
      r_zacc    <= 1'b1;
    end else if (w_accept) begin
      r_carry <= w_cout;
      r_zacc  <= w_zacc;
      if (w_first) r_sub_lat <= sub_sel;
    end else if (carry_clr) begin
      r_carry <= 1'b0;
    end
  end

  // One-deep output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_s         <= w_res;
      r_cout      <= w_cout;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Operation flags: written on eop, invalidated when a multi-word op opens.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_z      <= 1'b0;
      r_ovf    <= 1'b0;
      r_fvalid <= 1'b0;
    end else if (w_accept) begin
      if (eop) begin
        r_sign   <= w_sign;
        r_z      <= w_zacc;
        r_ovf    <= w_ovf;
        r_fvalid <= 1'b1;
      end else if (w_first) begin
        r_fvalid <= 1'b0;
      end
    end
  end

  assign s           = r_s;
  assign cout        = r_cout;
  assign out_valid   = r_out_valid;
  assign flags_valid = r_fvalid;
  assign sign_reg    = r_sign;
  assign z_reg       = r_z;
  assign ovf_reg     = r_ovf;

endmodule

// File: tb/tb_add_sub_mp.sv
// tb_add_sub_mp: drives a signed and an unsigned add_sub_mp with identical
// stimulus and checks both against a word-level arithmetic model.
module tb_add_sub_mp;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, sub_sel = 1'b0, sop = 1'b0, eop = 1'b0;
  logic         carry_clr = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;

  logic         s_in_ready, s_out_valid, s_cout, s_fv, s_sign, s_z, s_ovf;
  logic         u_in_ready, u_out_valid, u_cout, u_fv, u_sign, u_z, u_ovf;
  logic [W-1:0] s_s, u_s;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  add_sub_mp #(.WIDTH(W), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .sub_sel(sub_sel), .sop(sop), .eop(eop), .carry_clr(carry_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .s(s_s), .cout(s_cout),
    .flags_valid(s_fv), .sign_reg(s_sign), .z_reg(s_z), .ovf_reg(s_ovf));

  add_sub_mp #(.WIDTH(W), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .sub_sel(sub_sel), .sop(sop), .eop(eop), .carry_clr(carry_clr),
    .out_valid(u_out_valid), .out_ready(out_ready), .s(u_s), .cout(u_cout),
    .flags_valid(u_fv), .sign_reg(u_sign), .z_reg(u_z), .ovf_reg(u_ovf));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // ---------------- behavioural model ----------------
  bit       m_busy = 0, m_sub = 0, m_carry = 0, m_zero = 1, m_ov = 0, m_cout = 0;
  bit       m_fv = 0, m_sign_s = 0, m_ovf_s = 0, m_sign_u = 0, m_ovf_u = 0, m_z = 0;
  int       m_s = 0;

  always @(posedge clk) begin
    bit acc, first, cin, co;
    int bx, tot, res, v;
    if (!rst_n) begin
      m_busy = 0; m_sub = 0; m_carry = 0; m_zero = 1; m_ov = 0; m_cout = 0;
      m_fv = 0; m_sign_s = 0; m_ovf_s = 0; m_sign_u = 0; m_ovf_u = 0; m_z = 0; m_s = 0;
    end else begin
      acc = in_valid && (!m_ov || out_ready);
      if (acc) begin
        first = sop || !m_busy;
        if (first) m_sub = sub_sel;
        cin = first ? sub_sel : m_carry;
        bx  = m_sub ? (~int'(b) & 255) : int'(b);
        tot = int'(a) + bx + int'(cin);
        res = tot % 256;
        co  = (tot >= 256);
        v   = sx(a) + sx(W'(bx)) + int'(cin);
        m_zero = (first ? 1'b1 : m_zero) && (res == 0);
        if (eop) begin
          m_z = m_zero;
          m_ovf_s = (v > 127) || (v < -128);
          m_sign_s = (v < 0);
          m_sign_u = m_sub ? !co : co;
          m_ovf_u = co ^ m_sub;
          m_fv = 1;
          m_busy = 0;
        end else begin
          if (first) m_fv = 0;
          m_busy = 1;
        end
        m_carry = co;
        m_s = res; m_cout = co; m_ov = 1;
      end else begin
        if (carry_clr) m_carry = 0;
        if (out_ready) m_ov = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready_s", s_in_ready, rst_n && (!m_ov || out_ready));
      check("in_ready_u", u_in_ready, rst_n && (!m_ov || out_ready));
      check("out_valid_s", s_out_valid, m_ov);
      check("out_valid_u", u_out_valid, m_ov);
      check("s_s", s_s, m_s[W-1:0]);
      check("s_u", u_s, m_s[W-1:0]);
      check("cout_s", s_cout, m_cout);
      check("cout_u", u_cout, m_cout);
      check("fv_s", s_fv, m_fv);
      check("fv_u", u_fv, m_fv);
      check("z_s", s_z, m_z);
      check("z_u", u_z, m_z);
      check("sign_s", s_sign, m_sign_s);
      check("ovf_s", s_ovf, m_ovf_s);
      check("sign_u", u_sign, m_sign_u);
      check("ovf_u", u_ovf, m_ovf_u);
    end
  end

  // One word, presented for one cycle with out_ready high.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                      input logic tsop, input logic teop);
    a = ta; b = tb; sub_sel = tsub; sop = tsop; eop = teop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_out_valid", s_out_valid, 1'b0);
    check("rst_in_ready", s_in_ready, 1'b0);
    check("rst_s", s_s, 8'h00);
    check("rst_fv", s_fv, 1'b0);
    rst_n = 1'b1; #1;
    check("ready_after_rst", s_in_ready, 1'b1);

    // single-word subtract 05-07
    send(8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
    check("sub1_s", s_s, 8'hFE); check("sub1_cout", s_cout, 1'b0);
    check("sub1_sign", s_sign, 1'b1); check("sub1_z", s_z, 1'b0);
    check("sub1_ovf", s_ovf, 1'b0); check("sub1_ov", s_out_valid, 1'b1);

    // two-word add 0x01FF + 0x0001
    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    check("add2a_s", s_s, 8'h00); check("add2a_cout", s_cout, 1'b1);
    check("add2a_fv", s_fv, 1'b0);
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    check("add2b_s", s_s, 8'h02); check("add2b_cout", s_cout, 1'b0);
    check("add2_z", s_z, 1'b0); check("add2_sign", s_sign, 1'b0);

    // two-word subtract 0x1234 - 0x1234, sub_sel dropped on second word
    send(8'h34, 8'h34, 1'b1, 1'b1, 1'b0);
    check("sub2a_s", s_s, 8'h00);
    send(8'h12, 8'h12, 1'b0, 1'b0, 1'b1);
    check("sub2b_s", s_s, 8'h00); check("sub2_z", s_z, 1'b1);
    check("sub2_sign", s_sign, 1'b0); check("sub2_ovf", s_ovf, 1'b0);

    // signed overflow 7F+01 and unsigned borrow 03-05
    send(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    check("ovf_s", s_s, 8'h80); check("ovf_flag", s_ovf, 1'b1);
    check("ovf_sign", s_sign, 1'b0);
    send(8'h03, 8'h05, 1'b1, 1'b1, 1'b1);
    check("uns_sign", u_sign, 1'b1);

    // back-pressure for three cycles
    send(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
    held = s_s;
    check("bp_first", held, 8'h30);
    out_ready = 1'b0;
    a = 8'h01; b = 8'h01; sub_sel = 1'b0; sop = 1'b1; eop = 1'b1; in_valid = 1'b1;
    #1;
    check("bp_ready0", s_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_s", s_s, held);
      check("bp_hold_ready", s_in_ready, 1'b0);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", s_in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    check("bp_next_s", s_s, 8'h02);

    // reset in the middle of a two-word operation
    send(8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ov", s_out_valid, 1'b0); check("mid_rst_s", s_s, 8'h00);
    check("mid_rst_cout", s_cout, 1'b0); check("mid_rst_fv", s_fv, 1'b0);
    check("mid_rst_ready", s_in_ready, 1'b0);
    rst_n = 1'b1;
    send(8'h05, 8'h03, 1'b1, 1'b0, 1'b1);
    check("post_rst_s", s_s, 8'h02); check("post_rst_cout", s_cout, 1'b1);
    check("post_rst_fv", s_fv, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sop       = ($urandom_range(0, 3) == 0);
      eop       = ($urandom_range(0, 2) == 0);
      sub_sel   = 1'($urandom);
      carry_clr = ($urandom_range(0, 9) == 0);
      a         = 8'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sub_mp.md
ADD_SUB_MP -- requirements
Module: add_sub_mp

Interface
REQ-001: Parameter WIDTH, default 8; word width of operands and result; legal range 4..64.
REQ-002: Parameter SIGNED, default 1; 1 = flags use two's-complement interpretation, 0 = unsigned.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: in_valid  input  1  operand word present.
REQ-006: in_ready  output  1  unit accepts word this cycle.
REQ-007: a, b  input  WIDTH each  operand words, least-significant word first.
REQ-008: sub_sel  input  1  1 = A-B, 0 = A+B; sampled only on sop word.
REQ-009: sop  input  1  word is first word of an operation.
REQ-010: eop  input  1  word is last word of an operation.
REQ-011: carry_clr  input  1  synchronously clears carry register.
REQ-012: out_valid  output  1  result word present on s.
REQ-013: out_ready  input  1  downstream accepts result word.
REQ-014: s  output  WIDTH  registered result word.
REQ-015: cout  output  1  carry-out of word on s (raw adder carry, not borrow).
REQ-016: flags_valid  output  1  sign_reg/z_reg/ovf_reg updated by last eop; cleared on next sop acceptance.
REQ-017: sign_reg, z_reg, ovf_reg  output  1 each  registered operation flags.

Function
REQ-018: Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (one-deep output register, no combinational path in_valid->out_valid).
REQ-019: On accept, s <= a + (sub_sel_op ? ~b : b) + cin, modulo 2^WIDTH; out_valid set next cycle; latency 1 cycle.
REQ-020: cin = sub_sel on sop word; cin = carry register on non-sop words.
REQ-021: sub_sel_op = sub_sel on sop word, else the value latched at the current operation's sop; sub_sel ignored on non-sop words.
REQ-022: Carry register loads adder carry-out on every accept.
REQ-023: FSM states IDLE, BUSY; IDLE->BUSY on accepted sop without eop; BUSY->IDLE on accepted eop; sop+eop on one word = single-word operation, state stays IDLE.
REQ-024: Non-sop word accepted in IDLE treated as sop (cin = sub_sel, sub_sel latched).
REQ-025: sop word accepted in BUSY aborts prior operation: flags not updated for it, new operation starts, zero accumulator restarted.
REQ-026: Zero accumulator: on sop word = (result==0); on later words ANDed with (result==0).
REQ-027: On accepted eop word: z_reg <= accumulated zero including this word; ovf_reg <= signed overflow of this word (SIGNED=1) or (carry-out xor sub_sel_op) (SIGNED=0); flags_valid <= 1.
REQ-028: sign_reg on eop: SIGNED=1 -> result MSB xor ovf (true sign, A<B for subtract); SIGNED=0 -> subtract: !carry-out (borrow, A<B); add: carry-out.
REQ-029: Flags hold between eops; flags_valid cleared on accepted sop without eop.
REQ-030: carry_clr zeroes carry register; if coincident with accept, accept's carry-out wins; no effect on state, flags, outputs.
REQ-031: Output held stable while out_valid && !out_ready.

Reset
REQ-032: rst_n low at clock edge: out_valid=0, s=0, cout=0, carry=0, sign_reg=0, z_reg=0, ovf_reg=0, flags_valid=0, state=IDLE, zero accumulator=1, latched sub_sel=0.
REQ-033: Reset mid-operation discards all words in flight; in_ready=0 during reset, 1 in first cycle after release.

Verification
REQ-034: WIDTH=8, SIGNED=1: single word sop=eop=1, sub_sel=1, a=0x05, b=0x07 -> s=0xFE, cout=0, sign_reg=1, z_reg=0, ovf_reg=0, out_valid one cycle later.
REQ-035: WIDTH=8, two-word add 0x01FF+0x0001 (words FF/01 then 01/00) -> s=0x00 cout=1, then s=0x02 cout=0; z_reg=0, sign_reg=0.
REQ-036: WIDTH=8, two-word subtract 0x1234-0x1234 -> both s=0x00, z_reg=1, sign_reg=0, ovf_reg=0; sub_sel toggled on second word has no effect.
REQ-037: out_ready held 0 for 3 cycles with out_valid=1 -> in_ready=0, s stable; release -> next word accepted same cycle.
REQ-038: SIGNED=1 single-word add 0x7F+0x01 -> s=0x80, ovf_reg=1, sign_reg=0; SIGNED=0 subtract 0x03-0x05 -> sign_reg=1.
REQ-039: rst_n asserted after first word of two-word operation -> all outputs zero; following non-sop word treated as sop with cin=sub_sel.
